// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants: FSM state encoding, instruction
// width, PC increment and the default reset PC used by ROM and decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int          INSTR_W          = 32;
  localparam int          PC_INC           = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ins_fetch_pc_sel.sv
// Combinational ROM address priority mux (redirect > boot > stall-hold > pc)
// plus fault detection for the address being issued this cycle.
module ins_fetch_pc_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int IMEM_DEPTH = 512
) (
  input  fetch_state_e      i_state,
  input  logic [ADDR_W-1:0] i_pc_q,
  input  logic [ADDR_W-1:0] i_resp_pc_q,
  input  logic              i_resp_vld_q,
  input  logic              i_stall,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_hold,
  output logic              o_fault
);

  // One extra bit so IMEM_DEPTH*4 cannot overflow the address width.
  localparam logic [ADDR_W:0] IMEM_LIMIT = (ADDR_W + 1)'(IMEM_DEPTH) << 2;

  // NOTE: every output gets a default first, so no path leaves a latch.
  always_comb begin
    o_addr = i_pc_q;
    o_hold = 1'b0;
    if (i_redirect_valid) begin
      o_addr = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (i_state == BOOT) begin
      o_addr = i_pc_q;
    end else if (i_stall && i_resp_vld_q) begin
      o_addr = i_resp_pc_q;
      o_hold = 1'b1;
    end
  end

  assign o_fault = (i_redirect_valid && (i_redirect_pc[1:0] != 2'b00)) ||
                   ({1'b0, o_addr} >= IMEM_LIMIT);

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch initiator for a 1-cycle synchronous ROM: owns the PC,
// handles stall (re-issue held address) and redirect. Option: IF_PERF_CNT_EN.
module ins_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                IMEM_DEPTH = 512
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_fault
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        if_retire_cnt
`endif
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic              r_resp_vld;
  logic              r_fault;

  logic [ADDR_W-1:0] w_addr;
  logic              w_hold;
  logic              w_fault;

  ins_fetch_pc_sel #(
    .ADDR_W     (ADDR_W),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_pc_sel (
    .i_state          (r_state),
    .i_pc_q           (r_pc),
    .i_resp_pc_q      (r_resp_pc),
    .i_resp_vld_q     (r_resp_vld),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_addr           (w_addr),
    .o_hold           (w_hold),
    .o_fault          (w_fault)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_resp_vld <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_resp_pc  <= w_addr;
      r_resp_vld <= 1'b1;
      r_fault    <= w_fault;
      if (!w_hold) r_pc <= w_addr + ADDR_W'(PC_INC);
      // w_hold already excludes redirect and BOOT, so it alone picks HOLD.
      case (r_state)
        BOOT:    r_state <= RUN;
        RUN:     r_state <= w_hold ? HOLD : RUN;
        HOLD:    r_state <= w_hold ? HOLD : RUN;
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_retire_cnt <= 32'd0;
    else if (r_resp_vld && !stall && !redirect_valid) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign if_retire_cnt = r_retire_cnt;
`endif

  assign imem_addr = w_addr;
  assign if_valid  = r_resp_vld;
  assign if_pc     = r_resp_pc;
  assign if_instr  = imem_instr;
  assign if_fault  = r_fault;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Directed self-checking bench for ins_fetch_unit with a behavioural
// synchronous ROM returning 32'hA000_0000 + word index.
module tb_ins_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
`ifdef IF_PERF_CNT_EN
  logic [31:0] if_retire_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  ins_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (512)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
`ifdef IF_PERF_CNT_EN
    ,
    .if_retire_cnt  (if_retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM decodes only its 9 index bits, so 0x800 aliases word 0.
  always @(posedge clk) imem_instr <= 32'hA000_0000 + {23'd0, imem_addr[10:2]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=00000000", if_pc); end
    checks++; if (if_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", if_fault); end
    checks++; if (dut.r_state !== BOOT) begin failures++; $display("FAIL reset_state got=%0d exp=BOOT", dut.r_state); end
    rst = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL boot_addr got=%h exp=00000000", imem_addr); end
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL run_valid k=%0d got=%b exp=1", k, if_valid); end
      checks++; if (if_pc !== 32'(4 * k)) begin failures++; $display("FAIL run_pc k=%0d got=%h exp=%h", k, if_pc, 32'(4 * k)); end
      checks++; if (if_instr !== 32'hA000_0000 + 32'(k)) begin failures++; $display("FAIL run_instr k=%0d got=%h exp=%h", k, if_instr, 32'hA000_0000 + 32'(k)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL stall_addr got=%h exp=00000008", imem_addr); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (if_pc !== 32'h8) begin failures++; $display("FAIL stall_pc i=%0d got=%h exp=00000008", i, if_pc); end
      checks++; if (if_instr !== 32'hA000_0002) begin failures++; $display("FAIL stall_instr i=%0d got=%h exp=A0000002", i, if_instr); end
      checks++; if (dut.r_state !== HOLD) begin failures++; $display("FAIL stall_state i=%0d got=%0d exp=HOLD", i, dut.r_state); end
    end
    tick();
    stall = 1'b0;
    checks++; if (if_pc !== 32'h8) begin failures++; $display("FAIL release_pc got=%h exp=00000008", if_pc); end
    checks++; if (if_instr !== 32'hA000_0002) begin failures++; $display("FAIL release_instr got=%h exp=A0000002", if_instr); end
    #1;
    checks++; if (imem_addr !== 32'hC) begin failures++; $display("FAIL release_addr got=%h exp=0000000C", imem_addr); end
    tick();
    checks++; if (if_pc !== 32'hC) begin failures++; $display("FAIL after_stall_pc got=%h exp=0000000C", if_pc); end
    checks++; if (if_instr !== 32'hA000_0003) begin failures++; $display("FAIL after_stall_instr got=%h exp=A0000003", if_instr); end
    checks++; if (dut.r_state !== RUN) begin failures++; $display("FAIL after_stall_state got=%0d exp=RUN", dut.r_state); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    tick();
    redirect_pc = 32'h40;
    checks++; if (if_pc !== 32'h4) begin failures++; $display("FAIL redir_setup_pc got=%h exp=00000004", if_pc); end
    tick();
    redirect_valid = 1'b0;
    checks++; if (if_pc !== 32'h40) begin failures++; $display("FAIL redir_pc got=%h exp=00000040", if_pc); end
    checks++; if (if_instr !== 32'hA000_0010) begin failures++; $display("FAIL redir_instr got=%h exp=A0000010", if_instr); end
    checks++; if (if_fault !== 1'b0) begin failures++; $display("FAIL redir_fault got=%b exp=0", if_fault); end
    tick();
    checks++; if (if_pc !== 32'h44) begin failures++; $display("FAIL redir_next_pc got=%h exp=00000044", if_pc); end
    checks++; if (if_instr !== 32'hA000_0011) begin failures++; $display("FAIL redir_next_instr got=%h exp=A0000011", if_instr); end
  endtask

  task automatic test_redirect_stall();
    redirect_valid = 1'b1; redirect_pc = 32'h42; stall = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL rs_addr got=%h exp=00000040", imem_addr); end
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    checks++; if (if_pc !== 32'h40) begin failures++; $display("FAIL rs_pc got=%h exp=00000040", if_pc); end
    checks++; if (if_fault !== 1'b1) begin failures++; $display("FAIL rs_fault got=%b exp=1", if_fault); end
    checks++; if (dut.r_state !== RUN) begin failures++; $display("FAIL rs_state got=%0d exp=RUN", dut.r_state); end
    tick();
    checks++; if (if_pc !== 32'h44) begin failures++; $display("FAIL rs_next_pc got=%h exp=00000044", if_pc); end
    checks++; if (if_fault !== 1'b0) begin failures++; $display("FAIL rs_next_fault got=%b exp=0", if_fault); end
  endtask

  task automatic test_range_and_mid_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h7F8;
    tick();
    redirect_valid = 1'b0;
    checks++; if (if_pc !== 32'h7F8) begin failures++; $display("FAIL range_pc0 got=%h exp=000007F8", if_pc); end
    tick();
    checks++; if (if_pc !== 32'h7FC) begin failures++; $display("FAIL range_pc1 got=%h exp=000007FC", if_pc); end
    checks++; if (if_fault !== 1'b0) begin failures++; $display("FAIL range_fault1 got=%b exp=0", if_fault); end
    checks++; if (if_instr !== 32'hA000_01FF) begin failures++; $display("FAIL range_instr1 got=%h exp=A00001FF", if_instr); end
    tick();
    checks++; if (if_pc !== 32'h800) begin failures++; $display("FAIL range_pc2 got=%h exp=00000800", if_pc); end
    checks++; if (if_fault !== 1'b1) begin failures++; $display("FAIL range_fault2 got=%b exp=1", if_fault); end
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL range_valid2 got=%b exp=1", if_valid); end
    checks++; if (if_instr !== 32'hA000_0000) begin failures++; $display("FAIL range_instr2 got=%h exp=A0000000", if_instr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL midrst_pc got=%h exp=00000000", if_pc); end
    checks++; if (if_fault !== 1'b0) begin failures++; $display("FAIL midrst_fault got=%b exp=0", if_fault); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL midrst_first got=%b/%h exp=1/00000000", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (if_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc0 got=%h exp=FFFFFFFC", if_pc); end
    checks++; if (if_fault !== 1'b1) begin failures++; $display("FAIL wrap_fault0 got=%b exp=1", if_fault); end
    tick();
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc1 got=%h exp=00000000", if_pc); end
    checks++; if (if_fault !== 1'b0) begin failures++; $display("FAIL wrap_fault1 got=%b exp=0", if_fault); end
    checks++; if (if_instr !== 32'hA000_0000) begin failures++; $display("FAIL wrap_instr1 got=%h exp=A0000000", if_instr); end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (if_retire_cnt !== 32'd0) begin failures++; $display("FAIL perf_reset got=%0d exp=0", if_retire_cnt); end
    tick();
    for (int i = 0; i < 10; i++) begin
      stall          = (i == 3 || i == 4);
      redirect_valid = (i == 7);
      redirect_pc    = 32'h100;
      tick();
    end
    stall = 1'b0; redirect_valid = 1'b0;
    checks++; if (if_retire_cnt !== 32'd7) begin failures++; $display("FAIL perf_count got=%0d exp=7", if_retire_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_range_and_mid_reset();
    test_wrap();
`ifdef IF_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
- Fetch-side initiator for the synchronous instruction ROM, which returns the word addressed in cycle N on its data output in cycle N+1.
- Owns the program counter, drives the ROM address, and presents {valid, pc, instruction} to decode.
- Handles decode back-pressure (stall) and branch/jump redirect without a skid buffer: while stalled it re-issues the held address, so the ROM output stays stable.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- IMEM_DEPTH, 512, ROM depth in 32-bit words; fetches at or beyond IMEM_DEPTH*4 are faults.
- ADDR_W, 32, address/PC width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  byte address to ROM; combinational from state and redirect inputs.
- imem_instr  in  32  ROM read data, valid one cycle after the address.
- stall  in  1  decode cannot accept; hold the current output.
- redirect_valid  in  1  control-flow change request.
- redirect_pc  in  ADDR_W  redirect target byte address.
- if_valid  out  1  if_pc/if_instr hold a fetched instruction.
- if_pc  out  ADDR_W  byte address of if_instr.
- if_instr  out  32  instruction; equals imem_instr.
- if_fault  out  1  if_pc is misaligned-corrected or out of range.

Behaviour:
- Registers:
  - state.
  - pc_q: next address to issue.
  - resp_pc_q: address issued last cycle.
  - resp_vld_q.
  - fault_q.
- States:
  - BOOT: entered on reset.
  - RUN.
  - HOLD: stall asserted while resp_vld_q=1.
- Reset (rst=1 at a clock edge):
  - state=BOOT, pc_q=RESET_PC, resp_pc_q=RESET_PC, resp_vld_q=0, fault_q=0.
  - Outputs: if_valid=0, if_pc=RESET_PC, if_fault=0.
  - rst mid-stream discards any in-flight fetch. No instruction is delivered in the cycle after reset.
- Address mux, in priority order:
  1. redirect_valid → {redirect_pc[ADDR_W-1:2],2'b00}.
  2. BOOT → pc_q.
  3. stall & resp_vld_q → resp_pc_q (re-read the held word).
  4. Otherwise → pc_q.
- Each edge (rst=0):
  - resp_pc_q ← imem_addr.
  - resp_vld_q ← 1.
  - pc_q ← imem_addr+4, except under a stall-hold, where pc_q is unchanged.
  - fault_q ← (redirect_valid & redirect_pc[1:0]≠0) | (imem_addr ≥ IMEM_DEPTH*4).
- Outputs:
  - if_valid=resp_vld_q, if_pc=resp_pc_q, if_instr=imem_instr, if_fault=fault_q.
  - Latency from address issue to if_valid is 1 cycle.
  - Steady throughput is 1 instruction/cycle.
- Transitions:
  - BOOT→RUN unconditionally.
  - RUN→HOLD when stall & resp_vld_q.
  - HOLD→RUN when !stall.
  - Any state→RUN on redirect_valid.
- Stall:
  - While held, if_pc and if_instr are stable every cycle.
  - Stall with if_valid=0 has no effect.
- Redirect:
  - Redirect in cycle N: target appears at cycle N+1.
  - The word on the outputs in cycle N is the consumer's to discard; no extra bubble is inserted.
  - Redirect overrides a simultaneous stall.
- Wrap-around:
  - pc_q increments modulo 2^ADDR_W.
  - Addresses past IMEM_DEPTH*4 raise if_fault and keep fetching.
  - The ROM sees only its index bits.
- Faulted words are still delivered with if_valid=1; decode decides on a trap.

Optional Feature:
- IF_PERF_CNT_EN defined:
  - Adds output if_retire_cnt, 32 bits.
  - Counts cycles with if_valid & !stall & !redirect_valid.
  - Reset to 0; wraps at 2^32.
- IF_PERF_CNT_EN undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - State enum {BOOT, RUN, HOLD}.
  - Localparam INSTR_W=32 and PC_INC=4.
  - A default-reset-PC constant shared with the ROM and decode.
- One natural sub-module, ins_fetch_pc_sel: the combinational address-priority mux plus fault detection.
- The top level holds the registers and FSM.

Test Plan:
- Reset then free-run with ROM word k = 32'hA000_0000+k:
  - Cycle 1 after reset: if_valid=0.
  - Then if_pc=0,4,8… with if_instr=A0000000, A0000001… on consecutive cycles.
- Stall 3 cycles while if_pc=8:
  - if_pc=8 and if_instr=A0000002 are held for 3 cycles.
  - After release, next if_pc=12 with no skipped or duplicated word.
- Redirect to 0x40 while if_pc=4:
  - Next cycle if_pc=0x40, if_instr=A0000010.
  - Following cycle if_pc=0x44.
- Redirect 0x42 with stall=1 at the same time:
  - Next cycle if_pc=0x40, if_fault=1, FSM in RUN.
  - Following cycle if_fault=0.
- Run to if_pc=0x7FC:
  - Next if_pc=0x800 with if_fault=1.
  - rst asserted mid-run: next cycle if_valid=0 and if_pc=RESET_PC.
- With IF_PERF_CNT_EN: 10 free-run cycles with 2 stalled and 1 redirect → if_retire_cnt=7.
